// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: fetches the word at pc over a req/ack memory
// handshake, serves repeat fetches of the same pc from a one-entry buffer,
// stalls the pc register while a fetch is outstanding and reports faults.
module ifetch_unit #(
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        fetch_en,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        fetch_stall,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    localparam int unsigned    CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_MISALGN = 2'b01;
    localparam logic [1:0] CAUSE_BUSERR  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WAIT  = 2'b01,
        S_DRAIN = 2'b10,
        S_FAULT = 2'b11
    } state_t;

    state_t             state;
    logic               buf_valid;
    logic [31:0]        buf_pc;
    logic [31:0]        buf_data;
    logic [CNT_W-1:0]   wait_cnt;
    logic               hit;
    logic               cnt_expired;

    // Buffer hit is only honoured in IDLE so an in-flight fetch is never bypassed.
    assign hit         = fetch_en & buf_valid & (buf_pc == pc) & (state == S_IDLE) & ~flush;
    assign instr_valid = hit;
    assign instr       = buf_data;
    assign fetch_stall = fetch_en & ~hit;
    assign cnt_expired = (wait_cnt == CNT_LAST);

    // Fetch FSM: request issue, response capture, flush drain and fault tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= 32'h0;
            buf_valid   <= 1'b0;
            buf_pc      <= 32'h0;
            buf_data    <= NOP_INSTR;
            fault       <= 1'b0;
            fault_cause <= CAUSE_NONE;
            wait_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (flush) begin
                        buf_valid <= 1'b0;
                    end else if (fetch_en && !hit) begin
                        if (pc[1:0] != 2'b00) begin
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_MISALGN;
                            state       <= S_FAULT;
                        end else begin
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                            wait_cnt  <= '0;
                            state     <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (flush && imem_ack) begin
                        // Response arrived with the flush: drop it and finish at once.
                        imem_req  <= 1'b0;
                        buf_valid <= 1'b0;
                        state     <= S_IDLE;
                    end else if (flush) begin
                        // Request cannot be withdrawn; keep it up until the ack drains.
                        buf_valid <= 1'b0;
                        wait_cnt  <= wait_cnt + CNT_W'(1);
                        state     <= S_DRAIN;
                    end else if (imem_ack && !imem_err) begin
                        buf_pc    <= imem_addr;
                        buf_data  <= imem_rdata;
                        buf_valid <= 1'b1;
                        imem_req  <= 1'b0;
                        state     <= S_IDLE;
                    end else if (imem_ack) begin
                        imem_req    <= 1'b0;
                        fault       <= 1'b1;
                        fault_cause <= CAUSE_BUSERR;
                        state       <= S_FAULT;
                    end else if (cnt_expired) begin
                        imem_req    <= 1'b0;
                        fault       <= 1'b1;
                        fault_cause <= CAUSE_TIMEOUT;
                        state       <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                S_DRAIN: begin
                    if (imem_ack || cnt_expired) begin
                        imem_req <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                S_FAULT: begin
                    if (flush) begin
                        fault       <= 1'b0;
                        fault_cause <= CAUSE_NONE;
                        buf_valid   <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage directly downstream of the program-counter register. Consumes the current pc and fetches the 32-bit instruction from a variable-latency instruction memory over a req/ack handshake.
- A one-entry last-fetch buffer returns a repeat fetch of the same pc (e.g. a self-loop halt address) without a memory access.
- Asserts fetch_stall so the pc register holds while a fetch is outstanding.
- Reports misaligned, bus-error and timeout fetch faults.

Parameters:
- TIMEOUT, 16: max cycles in WAIT before fetch is abandoned (>=2).
- NOP_INSTR, 32'h00000013: value of instr while buffer invalid / after reset.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- pc  input  32  current program counter; stable while fetch_stall=1
- fetch_en  input  1  fetch requested this cycle
- flush  input  1  abort outstanding fetch, invalidate buffer, clear fault
- imem_req  output  1  memory request, registered
- imem_addr  output  32  word-aligned fetch address, registered
- imem_ack  input  1  memory response valid, sampled on clk
- imem_rdata  input  32  instruction word, valid with imem_ack
- imem_err  input  1  bus error, valid with imem_ack
- instr  output  32  fetched instruction (buffer data)
- instr_valid  output  1  instr corresponds to pc this cycle
- fetch_stall  output  1  pc register must hold
- fault  output  1  sticky fetch fault, registered
- fault_cause  output  2  01 misaligned, 10 bus error, 11 timeout, 00 none

Behaviour:
- Reset (async): state=IDLE, imem_req=0, imem_addr=0, buf_valid=0, buf_pc=0, buf_data=NOP_INSTR, fault=0, fault_cause=00, wait counter=0.
- Combinational outputs:
  - hit = fetch_en & buf_valid & (buf_pc==pc) & (state==IDLE) & ~flush
  - instr_valid = hit; instr = buf_data
  - fetch_stall = fetch_en & ~hit
- All other state changes occur on the rising edge of clk.
- States: IDLE, WAIT, DRAIN, FAULT.
- IDLE:
  - flush: buf_valid<=0; stay.
  - fetch_en & ~hit & pc[1:0]!=0: fault<=1, cause<=01, go FAULT; no request.
  - fetch_en & ~hit & aligned: imem_req<=1, imem_addr<=pc, counter<=0, go WAIT.
- WAIT:
  - imem_req/imem_addr held until ack; counter increments each cycle.
  - ack & ~err & ~flush: buf_pc<=imem_addr, buf_data<=imem_rdata, buf_valid<=1, imem_req<=0, go IDLE.
  - ack & err & ~flush: imem_req<=0, buffer unchanged, fault<=1, cause<=10, go FAULT.
  - flush & ack (same cycle): response discarded, imem_req<=0, buf_valid<=0, go IDLE.
  - flush & ~ack: buf_valid<=0, go DRAIN; req stays high (protocol: req cannot be withdrawn before ack).
  - counter reaches TIMEOUT-1 without ack: imem_req<=0, fault<=1, cause<=11, go FAULT. Any later stray ack is ignored.
- DRAIN:
  - Wait for ack; response (data or err) discarded, imem_req<=0, go IDLE.
  - Timeout counter continues; expiry goes to IDLE with no fault.
  - flush in DRAIN has no further effect.
- FAULT:
  - fault and cause held; fetch_stall=1 whenever fetch_en.
  - flush: fault<=0, cause<=00, buf_valid<=0, go IDLE.
- Latency:
  - Miss with ack in first WAIT cycle: pc presented in cycle 0, imem_req high in cycle 1, instr_valid in cycle 2 (2 stall cycles).
  - Each extra wait cycle adds 1.
  - Hit: 0 cycles.
- pc change while stalled (protocol violation): buffer is written with imem_addr, not the new pc. The following cycle misses and refetches; no corruption.
- fetch_en=0: no new request; an outstanding WAIT/DRAIN completes normally.
- Reset mid-WAIT: imem_req drops immediately; a late ack after reset is ignored (IDLE does not sample ack).

Test Plan:
- Reset, fetch_en=1, pc=0x5c, memory acks next cycle with 0x00500093 -> imem_req=1/imem_addr=0x5c in cycle 1; instr_valid=1, instr=0x00500093 in cycle 2; fetch_stall=1 in cycles 0-1.
- After that fetch, hold pc=0x5c 4 cycles -> instr_valid=1 every cycle, imem_req stays 0 (buffer hit). Change pc to 0x94 -> one new request to 0x94.
- pc=0x62 -> no imem_req; fault=1, cause=01 next cycle; stays until flush, then cause=00, state IDLE.
- Memory acks with imem_err=1 at pc=0x60 -> fault=1, cause=10, buffer still holds prior pc/data (no hit for 0x60).
- No ack for TIMEOUT=16 cycles -> imem_req low after cycle 16 of WAIT, cause=11; a later ack produces no buffer update.
- flush in 2nd WAIT cycle, ack with 0xDEADBEEF two cycles later -> imem_req held until ack, data discarded, buf_valid=0, next fetch of same pc issues new request. Repeat with flush and ack in the same cycle -> direct return to IDLE, no DRAIN.
